riscv_multicycle_sequencer: RTL and testbench
=============================================

// Module: riscv_multicycle_sequencer
// PURPOSE
//  Parametrised multi-cycle control/sequencing core for the RV32I softcore; replaces fixed PC+4 stepping and constant control.
//  Owns PC and instruction register (IR); runs FETCH/DECODE/EXECUTE/MEM/WB per instruction.
//  Drives control strobes to the external register_file, arithmetic_logic_unit, instruction_decoder and data_memory.
//  Uses req/ack handshakes so instruction and data memories may insert wait states.
// PARAMETERS
//  XLEN          32     datapath/address width (PC, ALU result, immediates)
//  RESET_VECTOR  'h0    PC value loaded by reset (XLEN bits)
// PORTS
//  clk_i          in   1     clock; everything updates on rising edge
//  reset_i        in   1     reset: synchronous, active-high
//  imem_req_o     out  1     instruction fetch request, held until ack
//  imem_addr_o    out  XLEN  fetch address (= pc_o)
//  imem_ack_i     in   1     fetch done; imem_rdata_i valid this cycle
//  imem_rdata_i   in   32    fetched instruction word
//  dmem_req_o     out  1     data access request, held until ack
//  dmem_we_o      out  1     1 = store, 0 = load; valid while dmem_req_o
//  dmem_ack_i     in   1     data access done
//  instr_o        out  32    IR contents, feeds instruction_decoder
//  pc_o           out  XLEN  PC of the instruction in flight
//  imm_b_i/imm_j_i in  XLEN  sign-extended B/J immediates from decoder
//  alu_zero_i     in   1     ALU result == 0
//  alu_control_o  out  3     ALU op (riscv_pkg ALU_* codes)
//  alu_src_imm_o  out  1     ALU operand 2: 1 = immediate_i, 0 = rs2
//  reg_write_o    out  1     register-file write enable, one cycle in WB
//  wb_sel_o       out  2     writeback source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM_U
//  retire_o       out  1     one-cycle pulse when an instruction completes
//  trap_o         out  1     sticky illegal-instruction flag (ILLEGAL_TRAP_EN only)
// BEHAVIOUR
//  Reset: state=FETCH, pc_o=RESET_VECTOR, IR=32'h00000013 (NOP).
//   All req/we/reg_write/retire/trap outputs 0; alu_control_o=ADD (3'b010); wb_sel_o=0.
//   imem_req_o is 0 while reset_i=1 and rises in the first cycle after release.
//  Handshake: acks count only while the matching req is 1; stray acks are ignored.
//   The ack cycle is the last cycle of that state (zero-wait ack means a 1-cycle state).
//  FETCH: imem_req_o=1; on imem_ack_i latch IR <= imem_rdata_i and go to DECODE.
//  DECODE (1 cycle) classifies opcode:
//   R 0110011 / I-ALU 0010011 -> EXEC -> WB (wb_sel ALU); alu_src_imm = I-type.
//   LOAD 0000011 f3=010 -> EXEC (ADD, imm) -> MEM (we=0) -> WB (wb_sel MEM).
//   STORE 0100011 f3=010 -> EXEC (ADD, imm) -> MEM (we=1) -> FETCH.
//   BRANCH 1100011 f3=000 BEQ / 001 BNE -> EXEC (SUB, rs2) -> FETCH.
//    taken = alu_zero_i ^ f3[0]; pc <= taken ? pc+imm_b_i : pc+4.
//   JAL 1101111 -> WB (wb_sel PC4); pc <= pc+imm_j_i.
//   LUI 0110111 -> WB (wb_sel IMM_U).
//  ALU decode for f3/f7[5]:
//   000/0 ADD, 000/1 SUB (R only), 111 AND, 110 OR, 010 SLT.
//   Any other funct, and any other opcode, is illegal.
//  PC update and retire_o happen in the final state of each class; the default PC update is pc+4.
//  PC is modulo 2^XLEN (wraps silently); pc[1:0] is forced to 00 on every update.
//  reg_write_o is asserted only in WB, exactly one cycle.
//  Cycles with zero-wait acks: R/I 4, LOAD 5, STORE 4, BRANCH 3, JAL/LUI 3; each wait cycle adds 1.
//  reset_i mid-MEM/FETCH: requests drop on the next edge, the instruction does not retire, no write occurs.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: an illegal instruction enters TRAP.
//   TRAP sets trap_o=1 and issues no further requests, retire or writes until reset_i.
//  ILLEGAL_TRAP_EN undefined: an illegal instruction executes as a NOP.
//   DECODE -> FETCH, pc+4, retire_o pulses; trap_o tied 0.
// STRUCTURE
//  riscv_pkg holds the shared definitions:
//   opcode localparams, ALU_AND/OR/ADD/SUB/SLT = 000/001/010/110/111,
//   WB_ALU/MEM/PC4/IMMU, and state encodings.
//  Sub-module riscv_ctrl_decode: combinational IR -> {class, alu_control, alu_src_imm, legal}.
//  This module keeps the FSM, PC, IR and handshakes.
// TESTING
//  1. RESET_VECTOR='h100, reset 2 cycles -> pc_o=0x100, imem_req_o=0 during reset, 1 on the first cycle after.
//  2. ADDI x1,x0,5 (0x00500093) at 0x100, zero-wait -> alu_control 010, alu_src_imm 1.
//     Also reg_write_o+retire_o in cycle 4, then pc_o=0x104.
//  3. LW with dmem_ack_i 3 cycles late -> dmem_req_o high 4 cycles, we=0.
//     Also one reg_write_o with wb_sel=1, retire at cycle 8.
//  4. BEQ at 0x108, imm_b_i=-8, alu_zero_i=1 -> pc_o=0x100 after 3 cycles, no reg_write.
//     Same with alu_zero_i=0 -> 0x10C.
//  5. JAL at 0x100, imm_j_i=16 -> wb_sel=2 with reg_write_o in cycle 3, pc_o=0x110.
//  6. IR=0xFFFFFFFF -> with ILLEGAL_TRAP_EN: trap_o=1, no further imem_req_o.
//     Without: retire_o, pc+4, no writes.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, ALU and
// writeback select codes, FSM state and instruction class encodings.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMMU = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_LUI
  } instr_class_t;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational classifier: opcode/funct fields of the IR to instruction
// class, ALU operation, operand-2 select and a legality flag.
import riscv_pkg::*;

module riscv_ctrl_decode (
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_t instr_class,
  output logic [2:0]   alu_control,
  output logic         alu_src_imm,
  output logic         legal
);

  always_comb begin
    instr_class = CLS_ALU;
    alu_control = ALU_ADD;
    alu_src_imm = 1'b0;
    legal       = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        alu_src_imm = (opcode == OP_I);
        legal       = 1'b1;
        case (funct3)
          3'b000:  alu_control = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b010:  alu_control = ALU_SLT;
          default: legal = 1'b0;
        endcase
        // For I-type funct7 is immediate bits; for R-type only SUB may set it.
        if (opcode == OP_R && funct7 != 7'b0000000 &&
            !(funct3 == 3'b000 && funct7 == 7'b0100000))
          legal = 1'b0;
      end
      OP_LOAD: begin
        instr_class = CLS_LOAD;
        alu_src_imm = 1'b1;
        legal       = (funct3 == 3'b010);
      end
      OP_STORE: begin
        instr_class = CLS_STORE;
        alu_src_imm = 1'b1;
        legal       = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        instr_class = CLS_BRANCH;
        alu_control = ALU_SUB;
        legal       = (funct3[2:1] == 2'b00);
      end
      OP_JAL: begin
        instr_class = CLS_JAL;
        legal       = 1'b1;
      end
      OP_LUI: begin
        instr_class = CLS_LUI;
        legal       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_sequencer.sv
// Multi-cycle RV32I control core: owns PC/IR, sequences FETCH..WB with
// req/ack memories. Define ILLEGAL_TRAP_EN to trap on illegal instructions.
import riscv_pkg::*;

module riscv_multicycle_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  input  logic            dmem_ack_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] imm_b_i,
  input  logic [XLEN-1:0] imm_j_i,
  input  logic            alu_zero_i,
  output logic [2:0]      alu_control_o,
  output logic            alu_src_imm_o,
  output logic            reg_write_o,
  output logic [1:0]      wb_sel_o,
  output logic            retire_o,
  output logic            trap_o
);

  // state    | meaning
  // S_FETCH  | imem request held until ack, IR loaded on ack
  // S_DECODE | classify IR; illegal -> TRAP or NOP retire
  // S_EXEC   | drive ALU; branches resolve and retire here
  // S_MEM    | dmem request held until ack; stores retire here
  // S_WB     | single-cycle register write and retire
  // S_TRAP   | sticky halt after an illegal instruction

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_target;
  logic [31:0]     ir_q;
  logic            ir_load, pc_load;
  logic            imem_req, reg_write, retire;

  instr_class_t dec_class;
  logic [2:0]   dec_alu;
  logic         dec_src_imm, dec_legal;

  riscv_ctrl_decode u_decode (
    .opcode      (ir_q[6:0]),
    .funct3      (ir_q[14:12]),
    .funct7      (ir_q[31:25]),
    .instr_class (dec_class),
    .alu_control (dec_alu),
    .alu_src_imm (dec_src_imm),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= imem_rdata_i;
      if (pc_load) pc_q <= {pc_target[XLEN-1:2], 2'b00};
    end
  end

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    reg_write     = 1'b0;
    retire        = 1'b0;
    wb_sel_o      = WB_ALU;
    alu_control_o = ALU_ADD;
    alu_src_imm_o = 1'b0;
    ir_load       = 1'b0;
    pc_load       = 1'b0;
    pc_target     = pc_q + XLEN'(4);
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack_i) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_control_o = dec_alu;
        alu_src_imm_o = dec_src_imm;
        if (!dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire  = 1'b1;
          pc_load = 1'b1;
          state_d = S_FETCH;
`endif
        end else if (dec_class == CLS_JAL || dec_class == CLS_LUI) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_control_o = dec_alu;
        alu_src_imm_o = dec_src_imm;
        if (dec_class == CLS_BRANCH) begin
          // funct3[0] distinguishes BNE from BEQ
          if (alu_zero_i ^ ir_q[12]) pc_target = pc_q + imm_b_i;
          pc_load = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (dec_class == CLS_LOAD || dec_class == CLS_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_control_o = dec_alu;
        alu_src_imm_o = dec_src_imm;
        dmem_req_o    = 1'b1;
        dmem_we_o     = (dec_class == CLS_STORE);
        if (dmem_ack_i) begin
          if (dec_class == CLS_STORE) begin
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_control_o = dec_alu;
        alu_src_imm_o = dec_src_imm;
        reg_write     = 1'b1;
        retire        = 1'b1;
        pc_load       = 1'b1;
        case (dec_class)
          CLS_LOAD: wb_sel_o = WB_MEM;
          CLS_JAL: begin
            wb_sel_o  = WB_PC4;
            pc_target = pc_q + imm_j_i;
          end
          CLS_LUI:  wb_sel_o = WB_IMMU;
          default:  wb_sel_o = WB_ALU;
        endcase
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is asserted so nothing is issued or committed.
  assign imem_req_o  = imem_req & ~reset_i;
  assign reg_write_o = reg_write & ~reset_i;
  assign retire_o    = retire & ~reset_i;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = ir_q;

`ifdef ILLEGAL_TRAP_EN
  assign trap_o = (state_q == S_TRAP);
`else
  assign trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_sequencer.sv
// Self-checking bench for riscv_multicycle_sequencer: table of single
// instructions with hand-computed timing/outputs, plus reset and illegal cases.
module tb_riscv_multicycle_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        imem_req_o, imem_ack_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = 32'h0;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i = 1'b0;
  logic [31:0] instr_o, pc_o;
  logic [31:0] imm_b_i = 32'h0, imm_j_i = 32'h0;
  logic        alu_zero_i = 1'b0;
  logic [2:0]  alu_control_o;
  logic        alu_src_imm_o, reg_write_o, retire_o, trap_o;
  logic [1:0]  wb_sel_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  riscv_multicycle_sequencer #(.XLEN(32), .RESET_VECTOR(32'h100)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .instr_o(instr_o), .pc_o(pc_o), .imm_b_i(imm_b_i), .imm_j_i(imm_j_i),
    .alu_zero_i(alu_zero_i), .alu_control_o(alu_control_o), .alu_src_imm_o(alu_src_imm_o),
    .reg_write_o(reg_write_o), .wb_sel_o(wb_sel_o), .retire_o(retire_o), .trap_o(trap_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic        zero;
    int          imem_wait;
    int          dmem_wait;
    int          exp_cycles;
    logic [2:0]  exp_alu;
    logic        exp_src;
    int          exp_rw;
    logic [1:0]  exp_wb;
    int          exp_dmem;
    logic        exp_we;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at the negedge of a FETCH cycle; returns at the negedge of the next FETCH.
  task automatic run_instr(input vec_t v, input string tag);
    int icnt = 0, dcnt = 0, rw_cnt = 0, cyc = 0;
    logic after_ack = 1'b0, alu_done = 1'b0, retired = 1'b0;
    logic [2:0] alu_seen = 3'b0;
    logic src_seen = 1'b0, we_seen = 1'b0;
    logic [1:0] wb_seen = 2'b0;
    imem_rdata_i = v.instr;
    imm_b_i      = v.imm_b;
    imm_j_i      = v.imm_j;
    alu_zero_i   = v.zero;
    while (!retired && cyc < 40) begin
      cyc++;
      imem_ack_i = imem_req_o && (icnt == v.imem_wait);
      dmem_ack_i = dmem_req_o && (dcnt == v.dmem_wait);
      #1;
      if (imem_req_o) icnt++;
      if (dmem_req_o) begin dcnt++; we_seen = dmem_we_o; end
      if (after_ack && !alu_done) begin
        alu_seen = alu_control_o; src_seen = alu_src_imm_o; alu_done = 1'b1;
      end
      if (imem_ack_i) after_ack = 1'b1;
      if (reg_write_o) begin rw_cnt++; wb_seen = wb_sel_o; end
      if (retire_o) retired = 1'b1;
      @(negedge clk_i);
    end
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    check({tag, " retired"}, 32'(retired), 32'd1);
    check({tag, " cycles"}, 32'(cyc), 32'(v.exp_cycles));
    check({tag, " alu_control"}, 32'(alu_seen), 32'(v.exp_alu));
    check({tag, " alu_src_imm"}, 32'(src_seen), 32'(v.exp_src));
    check({tag, " reg_write count"}, 32'(rw_cnt), 32'(v.exp_rw));
    if (v.exp_rw > 0) check({tag, " wb_sel"}, 32'(wb_seen), 32'(v.exp_wb));
    check({tag, " dmem_req cycles"}, 32'(dcnt), 32'(v.exp_dmem));
    if (v.exp_dmem > 0) check({tag, " dmem_we"}, 32'(we_seen), 32'(v.exp_we));
    check({tag, " next pc"}, pc_o, v.exp_pc);
    check({tag, " imem_addr"}, imem_addr_o, v.exp_pc);
  endtask

  initial begin
    vec_t v;
    int bad, dseen;

    //          instr         imm_b         imm_j         z    iw dw cyc alu     src  rw wb     dm we    next pc
    tbl[0]  = '{32'h00500093, 32'h0,        32'h0,        1'b0, 0, 0, 4, 3'b010, 1'b1, 1, 2'd0, 0, 1'b0, 32'h104};
    tbl[1]  = '{32'h002081B3, 32'h0,        32'h0,        1'b0, 0, 0, 4, 3'b010, 1'b0, 1, 2'd0, 0, 1'b0, 32'h108};
    tbl[2]  = '{32'h00208063, 32'hFFFFFFF8, 32'h0,        1'b1, 0, 0, 3, 3'b110, 1'b0, 0, 2'd0, 0, 1'b0, 32'h100};
    tbl[3]  = '{32'h000000EF, 32'h0,        32'h10,       1'b0, 0, 0, 3, 3'b010, 1'b0, 1, 2'd2, 0, 1'b0, 32'h110};
    tbl[4]  = '{32'h402081B3, 32'h0,        32'h0,        1'b0, 0, 0, 4, 3'b110, 1'b0, 1, 2'd0, 0, 1'b0, 32'h114};
    tbl[5]  = '{32'h0020F1B3, 32'h0,        32'h0,        1'b0, 0, 0, 4, 3'b000, 1'b0, 1, 2'd0, 0, 1'b0, 32'h118};
    tbl[6]  = '{32'h0030E093, 32'h0,        32'h0,        1'b0, 0, 0, 4, 3'b001, 1'b1, 1, 2'd0, 0, 1'b0, 32'h11C};
    tbl[7]  = '{32'h0020A1B3, 32'h0,        32'h0,        1'b0, 0, 0, 4, 3'b111, 1'b0, 1, 2'd0, 0, 1'b0, 32'h120};
    tbl[8]  = '{32'h0020A023, 32'h0,        32'h0,        1'b0, 1, 2, 7, 3'b010, 1'b1, 0, 2'd0, 3, 1'b1, 32'h124};
    tbl[9]  = '{32'h0000A203, 32'h0,        32'h0,        1'b0, 0, 3, 8, 3'b010, 1'b1, 1, 2'd1, 4, 1'b0, 32'h128};
    tbl[10] = '{32'h123452B7, 32'h0,        32'h0,        1'b0, 0, 0, 3, 3'b010, 1'b0, 1, 2'd3, 0, 1'b0, 32'h12C};
    tbl[11] = '{32'h00209063, 32'hFFFFFFDC, 32'h0,        1'b0, 0, 0, 3, 3'b110, 1'b0, 0, 2'd0, 0, 1'b0, 32'h108};
    tbl[12] = '{32'h00208063, 32'hFFFFFFF8, 32'h0,        1'b0, 0, 0, 3, 3'b110, 1'b0, 0, 2'd0, 0, 1'b0, 32'h10C};
    tbl[13] = '{32'h00209063, 32'hFFFFFFF8, 32'h0,        1'b1, 0, 0, 3, 3'b110, 1'b0, 0, 2'd0, 0, 1'b0, 32'h110};
    tbl[14] = '{32'h00500093, 32'h0,        32'h0,        1'b0, 2, 0, 6, 3'b010, 1'b1, 1, 2'd0, 0, 1'b0, 32'h114};
    tbl[15] = '{32'h000000EF, 32'h0,        32'hFFFFFFEA, 1'b0, 0, 0, 3, 3'b010, 1'b0, 1, 2'd2, 0, 1'b0, 32'h0FC};
    tbl[16] = '{32'h00209063, 32'hFFFFFF00, 32'h0,        1'b0, 0, 0, 3, 3'b110, 1'b0, 0, 2'd0, 0, 1'b0, 32'hFFFFFFFC};
    tbl[17] = '{32'h00500093, 32'h0,        32'h0,        1'b0, 0, 0, 4, 3'b010, 1'b1, 1, 2'd0, 0, 1'b0, 32'h000};

    // Reset held for two cycles
    @(negedge clk_i);
    check("reset imem_req c1", 32'(imem_req_o), 32'd0);
    @(negedge clk_i);
    check("reset imem_req c2", 32'(imem_req_o), 32'd0);
    check("reset pc", pc_o, 32'h100);
    check("reset ir", instr_o, 32'h00000013);
    check("reset alu_control", 32'(alu_control_o), 32'd2);
    check("reset wb_sel", 32'(wb_sel_o), 32'd0);
    check("reset dmem_req", 32'(dmem_req_o), 32'd0);
    check("reset dmem_we", 32'(dmem_we_o), 32'd0);
    check("reset reg_write", 32'(reg_write_o), 32'd0);
    check("reset retire", 32'(retire_o), 32'd0);
    check("reset trap", 32'(trap_o), 32'd0);
    reset_i = 1'b0;
    #1;
    check("first fetch imem_req", 32'(imem_req_o), 32'd1);

    for (int i = 0; i < 18; i++) run_instr(tbl[i], $sformatf("row%0d", i));

    // Reset while a load is stalled in MEM: no retire, no write, requests drop
    imem_rdata_i = 32'h0000A203;
    dmem_ack_i   = 1'b0;
    bad   = 0;
    dseen = 0;
    for (int c = 1; c <= 5; c++) begin
      imem_ack_i = (c == 1);
      #1;
      if (c >= 4 && dmem_req_o) dseen++;
      if (reg_write_o || retire_o) bad++;
      @(negedge clk_i);
    end
    imem_ack_i = 1'b0;
    reset_i    = 1'b1;
    #1;
    if (reg_write_o || retire_o) bad++;
    @(negedge clk_i);
    check("midmem dmem_req before reset", 32'(dseen), 32'd2);
    check("midmem dmem_req after reset", 32'(dmem_req_o), 32'd0);
    check("midmem imem_req in reset", 32'(imem_req_o), 32'd0);
    check("midmem no retire/write", 32'(bad), 32'd0);
    check("midmem pc", pc_o, 32'h100);
    reset_i = 1'b0;
    #1;
    check("midmem fetch after release", 32'(imem_req_o), 32'd1);

`ifdef ILLEGAL_TRAP_EN
    imem_rdata_i = 32'hFFFFFFFF;
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      imem_ack_i = (c == 1) || (c > 3);
      dmem_ack_i = (c > 3);
      #1;
      if (c >= 3 && (imem_req_o || dmem_req_o || retire_o || reg_write_o || !trap_o)) bad++;
      if (c < 3 && (retire_o || reg_write_o)) bad++;
      @(negedge clk_i);
    end
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    check("trap sticky and silent", 32'(bad), 32'd0);
    check("trap flag", 32'(trap_o), 32'd1);
    check("trap pc held", pc_o, 32'h100);
`else
    v = '{32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 0, 0, 2, 3'b010, 1'b0, 0, 2'd0, 0, 1'b0, 32'h104};
    run_instr(v, "illegal_opcode");
    v = '{32'h002091B3, 32'h0, 32'h0, 1'b0, 0, 0, 2, 3'b010, 1'b0, 0, 2'd0, 0, 1'b0, 32'h108};
    run_instr(v, "illegal_funct");
    check("trap tied low", 32'(trap_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
